// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
//   Turns the cache miss interface (rd_*/wr_*) into AXI4 master transactions.
//   One outstanding read and one outstanding write at a time; a read that
//   targets the same 16-byte line as an in-flight (or same-cycle) write is
//   held off until that write has received its B response.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   rd_req/rd_type/rd_addr/rd_rdy cache read request channel
//   ret_valid/ret_last/ret_data   read return beats (combinational from R)
//   wr_req/wr_type/wr_addr/
//   wr_wstrb/wr_data/wr_rdy       cache write request channel
//   ar*/r*                        AXI read address / data channels
//   aw*/w*/b*                     AXI write address / data / response channels
module cache_axi_bridge (
  input  logic         clk,
  input  logic         reset,
  // cache read side
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  // cache write side
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  // AXI read address
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  // AXI read data
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  // AXI write address
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  // AXI write data
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  // AXI write response
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  localparam logic [3:0] RD_ID = 4'd0;
  localparam logic [3:0] WR_ID = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_SEND = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // ---------------------------------------------------------------- state
  logic [1:0]   r_state_q, r_state_d;
  logic [31:0]  rd_addr_q, rd_addr_d;
  logic [2:0]   rd_type_q, rd_type_d;

  logic [1:0]   w_state_q, w_state_d;
  logic [31:0]  wr_addr_q, wr_addr_d;
  logic [2:0]   wr_type_q, wr_type_d;
  logic [3:0]   wr_wstrb_q, wr_wstrb_d;
  logic [127:0] wr_data_q, wr_data_d;
  logic [1:0]   beat_q, beat_d;
  logic         aw_done_q, aw_done_d;
  // Set once the last W beat has handshaken, so wvalid drops while AW may
  // still be waiting for awready.
  logic         w_done_q, w_done_d;

  // Response IDs and codes carry no information for this bridge.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, bid, bresp};

  // ---------------------------------------------------------------- hazard
  logic hazard;
  logic rd_line, wr_line;

  assign wr_rdy = (w_state_q == W_IDLE);
  // A read may not overtake a write to the same line: either one already in
  // flight, or one being accepted this very cycle.
  assign hazard = ((w_state_q != W_IDLE) && (rd_addr[31:4] == wr_addr_q[31:4])) ||
                  (wr_req && wr_rdy && (rd_addr[31:4] == wr_addr[31:4]));
  assign rd_rdy = (r_state_q == R_IDLE) && !hazard;

  // ---------------------------------------------------------------- read side
  assign rd_line   = (rd_type_q == 3'b100);
  assign arid      = RD_ID;
  assign araddr    = rd_addr_q;
  assign arlen     = rd_line ? 8'd3 : 8'd0;
  assign arsize    = rd_line ? 3'd2 : {1'b0, rd_type_q[1:0]};
  assign arburst   = BURST_INCR;
  assign arvalid   = (r_state_q == R_AR);
  assign rready    = (r_state_q == R_DATA);
  assign ret_valid = rready && rvalid;
  assign ret_last  = rready && rlast;
  assign ret_data  = rdata;

  always_comb begin
    r_state_d = r_state_q;
    rd_addr_d = rd_addr_q;
    rd_type_d = rd_type_q;
    case (r_state_q)
      R_IDLE: begin
        if (rd_req && rd_rdy) begin
          r_state_d = R_AR;
          rd_addr_d = rd_addr;
          rd_type_d = rd_type;
        end
      end
      R_AR:   if (arready) r_state_d = R_DATA;
      R_DATA: if (rvalid && rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- write side
  logic aw_hs, w_hs;

  assign wr_line = (wr_type_q == 3'b100);
  assign awid    = WR_ID;
  assign awaddr  = wr_addr_q;
  assign awlen   = wr_line ? 8'd3 : 8'd0;
  assign awsize  = wr_line ? 3'd2 : {1'b0, wr_type_q[1:0]};
  assign awburst = BURST_INCR;
  assign awvalid = (w_state_q == W_SEND) && !aw_done_q;
  assign wvalid  = (w_state_q == W_SEND) && !w_done_q;
  assign wdata   = wr_data_q[32*beat_q +: 32];
  assign wstrb   = wr_line ? 4'hF : wr_wstrb_q;
  assign wlast   = wvalid && (!wr_line || (beat_q == 2'd3));
  assign bready  = (w_state_q == W_RESP);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_comb begin
    w_state_d  = w_state_q;
    wr_addr_d  = wr_addr_q;
    wr_type_d  = wr_type_q;
    wr_wstrb_d = wr_wstrb_q;
    wr_data_d  = wr_data_q;
    beat_d     = beat_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_req) begin
          w_state_d  = W_SEND;
          wr_addr_d  = wr_addr;
          wr_type_d  = wr_type;
          wr_wstrb_d = wr_wstrb;
          wr_data_d  = wr_data;
          beat_d     = 2'd0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      W_SEND: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs) begin
          if (wlast) w_done_d = 1'b1;
          else       beat_d   = beat_q + 2'd1;
        end
        // AW and the last W beat may finish in either order or together.
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && wlast)))
          w_state_d = W_RESP;
      end
      W_RESP: begin
        if (bvalid) begin
          w_state_d = W_IDLE;
          beat_d    = 2'd0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q  <= R_IDLE;
      rd_addr_q  <= '0;
      rd_type_q  <= '0;
      w_state_q  <= W_IDLE;
      wr_addr_q  <= '0;
      wr_type_q  <= '0;
      wr_wstrb_q <= '0;
      wr_data_q  <= '0;
      beat_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_type_q  <= rd_type_d;
      w_state_q  <= w_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_type_q  <= wr_type_d;
      wr_wstrb_q <= wr_wstrb_d;
      wr_data_q  <= wr_data_d;
      beat_q     <= beat_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid, awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast, wvalid, wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_axi_bridge dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Advance to 1 ns after the next rising edge; inputs are driven here and
  // outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    #1;
    checks++; if (rd_rdy !== 1'b1)  begin errors++; $display("FAIL reset_rd_rdy got=%0b exp=1", rd_rdy); end
    checks++; if (wr_rdy !== 1'b1)  begin errors++; $display("FAIL reset_wr_rdy got=%0b exp=1", wr_rdy); end
    checks++; if ({arvalid, awvalid, wvalid, rready, bready, ret_valid, wlast} !== 7'b0)
      begin errors++; $display("FAIL reset_valids got=%b exp=0000000", {arvalid, awvalid, wvalid, rready, bready, ret_valid, wlast}); end
    checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr got=%h exp=0", araddr); end
    checks++; if (awaddr !== 32'h0) begin errors++; $display("FAIL reset_awaddr got=%h exp=0", awaddr); end
    checks++; if (wdata !== 32'h0)  begin errors++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (rd_rdy !== 1'b1 || arvalid !== 1'b0)
      begin errors++; $display("FAIL reset_release got rd_rdy=%0b arvalid=%0b exp 1/0", rd_rdy, arvalid); end
    $display("reset: done");
  endtask

  task automatic test_line_refill();
    rd_req = 1'b1; rd_addr = 32'h1C000010; rd_type = 3'b100;
    #1;
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL refill_accept rd_rdy got=%0b exp=1", rd_rdy); end
    tick();
    rd_req = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL refill_arvalid got=%0b exp=1", arvalid); end
    checks++; if (araddr !== 32'h1C000010) begin errors++; $display("FAIL refill_araddr got=%h exp=1c000010", araddr); end
    checks++; if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd3, 3'd2, 2'b01})
      begin errors++; $display("FAIL refill_arfields got id=%0d len=%0d size=%0d burst=%0d exp 0/3/2/1", arid, arlen, arsize, arburst); end
    checks++; if (rd_rdy !== 1'b0 || rready !== 1'b0)
      begin errors++; $display("FAIL refill_busy got rd_rdy=%0b rready=%0b exp 0/0", rd_rdy, rready); end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rdata = 32'hA0 + i; rlast = (i == 3);
      #1;
      checks++; if (ret_valid !== 1'b1 || ret_data !== 32'hA0 + i || ret_last !== (i == 3))
        begin errors++; $display("FAIL refill_beat%0d got valid=%0b data=%h last=%0b exp 1/%h/%0b", i, ret_valid, ret_data, ret_last, 32'hA0 + i, (i == 3)); end
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    checks++; if (rd_rdy !== 1'b1 || rready !== 1'b0 || arvalid !== 1'b0)
      begin errors++; $display("FAIL refill_done got rd_rdy=%0b rready=%0b arvalid=%0b exp 1/0/0", rd_rdy, rready, arvalid); end
    $display("read line 0x1C000010: 4 beats");
  endtask

  task automatic test_uncached_write();
    wr_req = 1'b1; wr_addr = 32'hBFAF8001; wr_type = 3'b000; wr_wstrb = 4'b0010;
    wr_data = 128'h0000AB00;
    #1;
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL ucw_accept wr_rdy got=%0b exp=1", wr_rdy); end
    tick();
    wr_req = 1'b0;
    #1;
    checks++; if (wr_rdy !== 1'b0) begin errors++; $display("FAIL ucw_wr_rdy_low got=%0b exp=0", wr_rdy); end
    checks++; if ({awvalid, awid, awaddr, awlen, awsize} !== {1'b1, 4'd1, 32'hBFAF8001, 8'd0, 3'd0})
      begin errors++; $display("FAIL ucw_aw got v=%0b id=%0d addr=%h len=%0d size=%0d exp 1/1/bfaf8001/0/0", awvalid, awid, awaddr, awlen, awsize); end
    checks++; if ({wvalid, wdata, wstrb, wlast} !== {1'b1, 32'h0000AB00, 4'b0010, 1'b1})
      begin errors++; $display("FAIL ucw_w got v=%0b data=%h strb=%b last=%0b exp 1/0000ab00/0010/1", wvalid, wdata, wstrb, wlast); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL ucw_bready_early got=%0b exp=0", bready); end
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    #1;
    checks++; if ({awvalid, wvalid, bready, wr_rdy} !== 4'b0010)
      begin errors++; $display("FAIL ucw_resp got aw=%0b w=%0b b=%0b rdy=%0b exp 0/0/1/0", awvalid, wvalid, bready, wr_rdy); end
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    #1;
    checks++; if (wr_rdy !== 1'b1 || bready !== 1'b0)
      begin errors++; $display("FAIL ucw_done got wr_rdy=%0b bready=%0b exp 1/0", wr_rdy, bready); end
    $display("write byte 0xBFAF8001: done");
  endtask

  task automatic test_victim_writeback();
    logic [31:0] exp_w [4];
    int beat = 0;
    bit aw_seen = 0;
    exp_w[0] = 32'h00000000; exp_w[1] = 32'h11111111;
    exp_w[2] = 32'h22222222; exp_w[3] = 32'h33333333;
    wr_req = 1'b1; wr_addr = 32'h00002000; wr_type = 3'b100; wr_wstrb = 4'b0000;
    wr_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    tick();
    wr_req = 1'b0;
    for (int c = 0; c < 40 && !(aw_seen && beat == 4); c++) begin
      awready = (c == 5);
      wready  = (c % 2 == 1);
      #1;
      checks++; if (bready !== 1'b0) begin errors++; $display("FAIL victim_bready_early cyc=%0d got=%0b exp=0", c, bready); end
      checks++; if (awvalid !== !aw_seen) begin errors++; $display("FAIL victim_awvalid cyc=%0d got=%0b exp=%0b", c, awvalid, !aw_seen); end
      if (awvalid && awready) aw_seen = 1;
      if (wvalid && wready) begin
        checks++; if (beat > 3 || wdata !== exp_w[beat & 3] || wstrb !== 4'hF || wlast !== (beat == 3))
          begin errors++; $display("FAIL victim_beat%0d got data=%h strb=%b last=%0b exp %h/1111/%0b", beat, wdata, wstrb, wlast, exp_w[beat & 3], (beat == 3)); end
        beat++;
      end
      tick();
    end
    awready = 1'b0; wready = 1'b0;
    #1;
    checks++; if (beat !== 4 || !aw_seen) begin errors++; $display("FAIL victim_complete got beats=%0d aw=%0b exp 4/1", beat, aw_seen); end
    checks++; if (bready !== 1'b1 || wvalid !== 1'b0) begin errors++; $display("FAIL victim_bready got bready=%0b wvalid=%0b exp 1/0", bready, wvalid); end
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    #1;
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL victim_done wr_rdy got=%0b exp=1", wr_rdy); end
    $display("write line 0x00002000: 4 beats");
  endtask

  task automatic test_hazard();
    wr_req = 1'b1; wr_addr = 32'h00001230; wr_type = 3'b100; wr_wstrb = 4'h0;
    wr_data = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    tick();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 32'h00001234; rd_type = 3'b010;
    #1;
    checks++; if (rd_rdy !== 1'b0) begin errors++; $display("FAIL hazard_block got=%0b exp=0", rd_rdy); end
    tick();
    #1;
    checks++; if (rd_rdy !== 1'b0 || arvalid !== 1'b0)
      begin errors++; $display("FAIL hazard_hold got rd_rdy=%0b arvalid=%0b exp 0/0", rd_rdy, arvalid); end
    rd_addr = 32'h00005670;
    #1;
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL hazard_other_line got=%0b exp=1", rd_rdy); end
    tick();
    rd_req = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h00005670 || arlen !== 8'd0 || arsize !== 3'd2)
      begin errors++; $display("FAIL hazard_other_ar got v=%0b addr=%h len=%0d size=%0d exp 1/00005670/0/2", arvalid, araddr, arlen, arsize); end
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h5670CAFE;
    #1;
    checks++; if (ret_valid !== 1'b1 || ret_last !== 1'b1 || ret_data !== 32'h5670CAFE)
      begin errors++; $display("FAIL hazard_other_ret got v=%0b last=%0b data=%h exp 1/1/5670cafe", ret_valid, ret_last, ret_data); end
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    $display("read word 0x00005670: done alongside write");
    rd_req = 1'b1; rd_addr = 32'h00001234;
    awready = 1'b1; wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rd_rdy !== 1'b0) begin errors++; $display("FAIL hazard_during_w%0d got=%0b exp=0", i, rd_rdy); end
    end
    awready = 1'b0; wready = 1'b0;
    #1;
    checks++; if (bready !== 1'b1 || rd_rdy !== 1'b0)
      begin errors++; $display("FAIL hazard_wresp got bready=%0b rd_rdy=%0b exp 1/0", bready, rd_rdy); end
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    #1;
    checks++; if (rd_rdy !== 1'b1 || arvalid !== 1'b0)
      begin errors++; $display("FAIL hazard_release got rd_rdy=%0b arvalid=%0b exp 1/0", rd_rdy, arvalid); end
    tick();
    rd_req = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h00001234)
      begin errors++; $display("FAIL hazard_late_ar got v=%0b addr=%h exp 1/00001234", arvalid, araddr); end
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    $display("write line 0x00001230 then read 0x00001234: done");
  endtask

  task automatic test_same_cycle();
    wr_req = 1'b1; wr_addr = 32'h00008000; wr_type = 3'b010; wr_wstrb = 4'hF; wr_data = 128'h12345678;
    rd_req = 1'b1; rd_addr = 32'h00008000; rd_type = 3'b010;
    #1;
    checks++; if (wr_rdy !== 1'b1 || rd_rdy !== 1'b0)
      begin errors++; $display("FAIL same_accept got wr_rdy=%0b rd_rdy=%0b exp 1/0", wr_rdy, rd_rdy); end
    tick();
    wr_req = 1'b0;
    #1;
    checks++; if (wr_rdy !== 1'b0 || rd_rdy !== 1'b0 || arvalid !== 1'b0)
      begin errors++; $display("FAIL same_deferred got wr_rdy=%0b rd_rdy=%0b arvalid=%0b exp 0/0/0", wr_rdy, rd_rdy, arvalid); end
    checks++; if (awsize !== 3'd2 || wlast !== 1'b1 || wdata !== 32'h12345678)
      begin errors++; $display("FAIL same_w got size=%0d last=%0b data=%h exp 2/1/12345678", awsize, wlast, wdata); end
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    #1;
    checks++; if (rd_rdy !== 1'b0 || arvalid !== 1'b0)
      begin errors++; $display("FAIL same_during_b got rd_rdy=%0b arvalid=%0b exp 0/0", rd_rdy, arvalid); end
    tick();
    bvalid = 1'b0;
    #1;
    checks++; if (rd_rdy !== 1'b1 || arvalid !== 1'b0)
      begin errors++; $display("FAIL same_after_b got rd_rdy=%0b arvalid=%0b exp 1/0", rd_rdy, arvalid); end
    tick();
    rd_req = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h00008000)
      begin errors++; $display("FAIL same_ar got v=%0b addr=%h exp 1/00008000", arvalid, araddr); end
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    $display("same-cycle write/read 0x00008000: write first, read after B");
  endtask

  task automatic test_reset_mid();
    wr_req = 1'b1; wr_addr = 32'h00009000; wr_type = 3'b010; wr_wstrb = 4'hF; wr_data = 128'h77;
    rd_req = 1'b1; rd_addr = 32'h0000A000; rd_type = 3'b100;
    #1;
    checks++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1)
      begin errors++; $display("FAIL rmid_accept got rd_rdy=%0b wr_rdy=%0b exp 1/1", rd_rdy, wr_rdy); end
    tick();
    wr_req = 1'b0; rd_req = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'hC0 + i;
      tick();
    end
    rdata = 32'hC2;
    #1;
    checks++; if (ret_valid !== 1'b1 || ret_data !== 32'hC2)
      begin errors++; $display("FAIL rmid_beat2 got v=%0b data=%h exp 1/000000c2", ret_valid, ret_data); end
    reset = 1'b1;
    #1;
    checks++; if ({arvalid, awvalid, wvalid, rready, bready, ret_valid, wlast} !== 7'b0)
      begin errors++; $display("FAIL rmid_valids got=%b exp=0000000", {arvalid, awvalid, wvalid, rready, bready, ret_valid, wlast}); end
    checks++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1)
      begin errors++; $display("FAIL rmid_rdy got rd_rdy=%0b wr_rdy=%0b exp 1/1", rd_rdy, wr_rdy); end
    tick();
    reset = 1'b0; rvalid = 1'b0;
    #1;
    checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0 || rd_rdy !== 1'b1 || wr_rdy !== 1'b1)
      begin errors++; $display("FAIL rmid_after got av=%0b awv=%0b wv=%0b rr=%0b br=%0b rd=%0b wr=%0b exp 0/0/0/0/0/1/1", arvalid, awvalid, wvalid, rready, bready, rd_rdy, wr_rdy); end
    $display("reset during read beat 2: transactions abandoned");
  endtask

  initial begin
    reset = 1'b1;
    rd_req = 0; rd_type = 0; rd_addr = 0;
    wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
    test_reset();
    test_line_refill();
    test_uncached_write();
    test_victim_writeback();
    test_hazard();
    test_same_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
